// File: rtl/route_table_pkg.sv
// Shared types and sizing for the routing-table responder.
// Optional build macro: ROUTE_TABLE_MASK_EN adds a per-entry key mask.
package route_table_pkg;

    localparam int unsigned DEPTH  = 128;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned KEY_W  = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [0:0] {
        StIdle,
        StSearch
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [KEY_W-1:0]  key;
        logic [DATA_W-1:0] data;
`ifdef ROUTE_TABLE_MASK_EN
        logic [KEY_W-1:0]  mask;
`endif
    } entry_t;

endpackage

// File: rtl/route_table_storage.sv
// Routing-table entry storage: one write port, two combinational read ports.
// Optional build macro: ROUTE_TABLE_MASK_EN stores a per-entry key mask.
module route_table_storage
    import route_table_pkg::*;
(
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_address_i,
    input  logic [KEY_W-1:0]  wr_key_i,
    input  logic [DATA_W-1:0] wr_data_i,
`ifdef ROUTE_TABLE_MASK_EN
    input  logic [KEY_W-1:0]  wr_mask_i,
`endif
    input  logic              wr_valid_i,
    input  logic [ADDR_W-1:0] cmp_idx_i,
    output entry_t            cmp_entry_o,
    input  logic [ADDR_W-1:0] rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DEPTH-1:0]  valid_q;
    logic [KEY_W-1:0]  key_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
`ifdef ROUTE_TABLE_MASK_EN
    logic [KEY_W-1:0]  mask_q [DEPTH];
`endif

    // Valid bits are the only reset state; clearing them empties the table.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_address_i] <= wr_valid_i;
        end
    end

    // Entry payload, intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            key_q[wr_address_i]  <= wr_key_i;
            data_q[wr_address_i] <= wr_data_i;
`ifdef ROUTE_TABLE_MASK_EN
            mask_q[wr_address_i] <= wr_mask_i;
`endif
        end
    end

    // Read ports see pre-write contents during a same-cycle write.
    always_comb begin
        cmp_entry_o.valid = valid_q[cmp_idx_i];
        cmp_entry_o.key   = key_q[cmp_idx_i];
        cmp_entry_o.data  = data_q[cmp_idx_i];
`ifdef ROUTE_TABLE_MASK_EN
        cmp_entry_o.mask  = mask_q[cmp_idx_i];
`endif
        rd_data_o         = data_q[rd_idx_i];
    end

endmodule

// File: rtl/route_table_responder.sv
// Routing-table responder: sequential key search (one entry per cycle,
// lowest index wins) and single-cycle indexed reads.
// Optional build macro: ROUTE_TABLE_MASK_EN enables masked (prefix) matching.
module route_table_responder
    import route_table_pkg::*;
(
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              match_enable_i,
    input  logic [KEY_W-1:0]  data_in_i,
    output logic              match_found_o,
    output logic              match_done_o,
    output logic [ADDR_W-1:0] match_address_o,
    input  logic              read_enable_i,
    input  logic [ADDR_W-1:0] read_address_i,
    output logic [DATA_W-1:0] read_data_o,
    output logic              read_valid_o,
    output logic              busy_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_address_i,
    input  logic [KEY_W-1:0]  wr_key_i,
    input  logic [DATA_W-1:0] wr_data_i,
`ifdef ROUTE_TABLE_MASK_EN
    input  logic [KEY_W-1:0]  wr_mask_i,
`endif
    input  logic              wr_valid_i
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              match_found_q, match_found_d;
    logic              match_done_q, match_done_d;
    logic [ADDR_W-1:0] match_address_q, match_address_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              read_valid_q, read_valid_d;

    entry_t            cmp_entry;
    logic [DATA_W-1:0] rd_data;
    logic              hit;

    route_table_storage u_storage (
        .clk_i        (clk_i),
        .resetn_i     (resetn_i),
        .wr_en_i      (wr_en_i),
        .wr_address_i (wr_address_i),
        .wr_key_i     (wr_key_i),
        .wr_data_i    (wr_data_i),
`ifdef ROUTE_TABLE_MASK_EN
        .wr_mask_i    (wr_mask_i),
`endif
        .wr_valid_i   (wr_valid_i),
        .cmp_idx_i    (idx_q),
        .cmp_entry_o  (cmp_entry),
        .rd_idx_i     (read_address_i),
        .rd_data_o    (rd_data)
    );

`ifdef ROUTE_TABLE_MASK_EN
    assign hit = cmp_entry.valid &&
                 ((cmp_entry.key & cmp_entry.mask) == (key_q & cmp_entry.mask));
`else
    assign hit = cmp_entry.valid && (cmp_entry.key == key_q);
`endif

    // Next-state and registered-output logic for the search/read FSM.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        key_d           = key_q;
        match_found_d   = 1'b0;
        match_done_d    = 1'b0;
        read_valid_d    = 1'b0;
        match_address_d = match_address_q;
        read_data_d     = read_data_q;
        unique case (state_q)
            StIdle: begin
                // A search request wins; a simultaneous read is dropped.
                if (match_enable_i) begin
                    key_d   = data_in_i;
                    idx_d   = '0;
                    state_d = StSearch;
                end else if (read_enable_i) begin
                    read_data_d  = rd_data;
                    read_valid_d = 1'b1;
                end
            end
            StSearch: begin
                if (hit) begin
                    match_found_d   = 1'b1;
                    match_done_d    = 1'b1;
                    match_address_d = idx_q;
                    read_data_d     = cmp_entry.data;
                    state_d         = StIdle;
                end else if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    match_done_d = 1'b1;
                    state_d      = StIdle;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q         <= StIdle;
            idx_q           <= '0;
            key_q           <= '0;
            match_found_q   <= 1'b0;
            match_done_q    <= 1'b0;
            match_address_q <= '0;
            read_data_q     <= '0;
            read_valid_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            key_q           <= key_d;
            match_found_q   <= match_found_d;
            match_done_q    <= match_done_d;
            match_address_q <= match_address_d;
            read_data_q     <= read_data_d;
            read_valid_q    <= read_valid_d;
        end
    end

    assign match_found_o   = match_found_q;
    assign match_done_o    = match_done_q;
    assign match_address_o = match_address_q;
    assign read_data_o     = read_data_q;
    assign read_valid_o    = read_valid_q;
    assign busy_o          = (state_q == StSearch);

endmodule

// File: tb/tb_route_table_responder.sv
// Self-checking bench for route_table_responder: directed scenarios plus
// randomized writes/reads/searches checked against a table model.
// Honours ROUTE_TABLE_MASK_EN when the design is built with it.
module tb_route_table_responder;
    import route_table_pkg::*;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              match_enable = 1'b0;
    logic [KEY_W-1:0]  data_in = '0;
    logic              match_found;
    logic              match_done;
    logic [ADDR_W-1:0] match_address;
    logic              read_enable = 1'b0;
    logic [ADDR_W-1:0] read_address = '0;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              busy;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_address = '0;
    logic [KEY_W-1:0]  wr_key = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [KEY_W-1:0]  wr_mask = '0;
    logic              wr_valid = 1'b0;

    always #5 clk = ~clk;

    route_table_responder dut (
        .clk_i           (clk),
        .resetn_i        (resetn),
        .match_enable_i  (match_enable),
        .data_in_i       (data_in),
        .match_found_o   (match_found),
        .match_done_o    (match_done),
        .match_address_o (match_address),
        .read_enable_i   (read_enable),
        .read_address_i  (read_address),
        .read_data_o     (read_data),
        .read_valid_o    (read_valid),
        .busy_o          (busy),
        .wr_en_i         (wr_en),
        .wr_address_i    (wr_address),
        .wr_key_i        (wr_key),
        .wr_data_i       (wr_data),
`ifdef ROUTE_TABLE_MASK_EN
        .wr_mask_i       (wr_mask),
`endif
        .wr_valid_i      (wr_valid)
    );

    // Reference model of the table and of the sticky outputs.
    bit                ref_valid [DEPTH];
    logic [KEY_W-1:0]  ref_key   [DEPTH];
    logic [DATA_W-1:0] ref_data  [DEPTH];
    logic [KEY_W-1:0]  ref_mask  [DEPTH];
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_rd = '0;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // First valid entry whose (masked) key equals k, or -1.
    function automatic int model_hit(input logic [KEY_W-1:0] k);
        for (int i = 0; i < DEPTH; i++) begin
            if (ref_valid[i] && ((ref_key[i] & ref_mask[i]) == (k & ref_mask[i]))) return i;
        end
        return -1;
    endfunction

    task automatic do_write(input int a, input logic [KEY_W-1:0] k, input logic [DATA_W-1:0] d,
                            input bit v, input logic [KEY_W-1:0] m);
        @(negedge clk);
        wr_en = 1'b1; wr_address = ADDR_W'(a); wr_key = k; wr_data = d; wr_valid = v;
        wr_mask = m;
        @(posedge clk); #1;
        wr_en = 1'b0;
        ref_valid[a] = v; ref_key[a] = k; ref_data[a] = d;
`ifdef ROUTE_TABLE_MASK_EN
        ref_mask[a] = m;
`else
        ref_mask[a] = '1;
`endif
    endtask

    task automatic do_read(input int a);
        @(negedge clk);
        read_enable = 1'b1; read_address = ADDR_W'(a);
        @(posedge clk); #1;
        read_enable = 1'b0;
        exp_rd = ref_data[a];
        check("rd_valid", read_valid, 1);
        check("rd_data", read_data, exp_rd);
        check("rd_busy", busy, 0);
        @(posedge clk); #1;
        check("rd_pulse", read_valid, 0);
    endtask

    task automatic do_search(input logic [KEY_W-1:0] k, input bit rd_same, input bit rd_busy);
        int  exp_i;
        int  lat;
        int  cyc;
        bit  done;
        exp_i = model_hit(k);
        lat = (exp_i >= 0) ? exp_i + 1 : DEPTH;
        @(negedge clk);
        match_enable = 1'b1; data_in = k;
        read_enable = rd_same; read_address = ADDR_W'($urandom_range(0, DEPTH - 1));
        @(posedge clk); #1;
        match_enable = 1'b0; read_enable = 1'b0; data_in = $urandom;
        check("busy_start", busy, 1);
        check("rd_dropped", read_valid, 0);
        cyc = 0; done = 1'b0;
        while (!done && cyc < DEPTH + 4) begin
            @(negedge clk);
            if (rd_busy) begin
                read_enable = 1'($urandom_range(0, 1));
                read_address = ADDR_W'($urandom_range(0, DEPTH - 1));
            end
            @(posedge clk); #1;
            read_enable = 1'b0;
            cyc++;
            done = match_done;
            check("rd_while_busy", read_valid, 0);
            if (!done) check("found_early", match_found, 0);
        end
        if (exp_i >= 0) begin
            exp_addr = ADDR_W'(exp_i);
            exp_rd = ref_data[exp_i];
        end
        check("latency", cyc, lat);
        check("found", match_found, (exp_i >= 0) ? 1 : 0);
        check("address", match_address, exp_addr);
        check("srch_data", read_data, exp_rd);
        check("busy_end", busy, 0);
        @(posedge clk); #1;
        check("done_pulse", match_done, 0);
        check("found_pulse", match_found, 0);
    endtask

    initial begin
        int dones;
        for (int i = 0; i < DEPTH; i++) begin
            ref_valid[i] = 1'b0; ref_key[i] = '0; ref_data[i] = '0; ref_mask[i] = '1;
        end
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        check("rst_found", match_found, 0);
        check("rst_done", match_done, 0);
        check("rst_addr", match_address, 0);
        check("rst_rdata", read_data, 0);
        check("rst_rvalid", read_valid, 0);
        check("rst_busy", busy, 0);

        // Payload is not reset, so give every entry a known (invalid) value.
        for (int i = 0; i < DEPTH; i++) do_write(i, '0, '0, 1'b0, '1);

        do_read(5);
        do_write(3, 32'd46, 32'd69, 1'b1, '1);
        do_search(32'd46, 1'b0, 1'b0);
        do_search(32'd99, 1'b0, 1'b0);
        do_write(3, 32'd46, 32'd69, 1'b0, '1);
        do_write(2, 32'd46, 32'd21, 1'b1, '1);
        do_write(7, 32'd46, 32'd77, 1'b1, '1);
        do_search(32'd46, 1'b1, 1'b1);
        do_write(2, 32'd46, 32'd21, 1'b0, '1);
        do_search(32'd46, 1'b1, 1'b1);

        // Abort a search with reset at idx=10.
        do_write(100, 32'd77, 32'd5, 1'b1, '1);
        @(negedge clk);
        match_enable = 1'b1; data_in = 32'd77;
        @(posedge clk); #1;
        match_enable = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        check("abort_found", match_found, 0);
        check("abort_done", match_done, 0);
        check("abort_addr", match_address, 0);
        check("abort_rdata", read_data, 0);
        check("abort_busy", busy, 0);
        for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
        exp_addr = '0; exp_rd = '0;
        dones = 0;
        repeat (DEPTH) begin
            @(posedge clk); #1;
            if (match_done) dones++;
        end
        check("abort_no_done", dones, 0);
        do_search(32'd77, 1'b0, 1'b0);

`ifdef ROUTE_TABLE_MASK_EN
        do_write(0, 32'h0A00_0000, 32'h1234, 1'b1, 32'hFF00_0000);
        do_search(32'h0A0B_0C0D, 1'b0, 1'b0);
`endif

        // Randomized mix against the model; small key pool to force hits.
        for (int n = 0; n < 40; n++) begin
            logic [KEY_W-1:0] k;
            k = ($urandom_range(0, 3) == 0) ? KEY_W'($urandom) : KEY_W'($urandom_range(1, 6));
            case ($urandom_range(0, 2))
                0: do_write($urandom_range(0, DEPTH - 1), k, DATA_W'($urandom),
                            1'($urandom_range(0, 3) != 0), '1);
                1: do_read($urandom_range(0, DEPTH - 1));
                default: do_search(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/route_table_responder.md
# route_table_responder

Routing-table lookup responder on the memory side of the routing algorithm FSM. It stores up to DEPTH entries, each a valid bit, a 32-bit key (destination IP) and 32-bit route data (next-hop encoding and port info). It answers key searches (match_enable / data_in) with match_found and the matching entry's data on read_data. It also answers direct indexed reads (read_enable / read_address). A host-side write port populates the table.

## Interface
- DEPTH, 128: number of entries; a power of two.
- ADDR_W, 7: log2(DEPTH).
- KEY_W, 32: key width.
- DATA_W, 32: route data width.

- clk  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- match_enable  in  1  start search (sampled in IDLE only)
- data_in  in  KEY_W  search key, latched when the search starts
- match_found  out  1  one-cycle pulse, hit
- match_done  out  1  one-cycle pulse, search finished (hit or miss)
- match_address  out  ADDR_W  index of the hit; valid with match_found
- read_enable  in  1  indexed read request (sampled in IDLE only)
- read_address  in  ADDR_W  read index
- read_data  out  DATA_W  data of the hit entry or the read entry
- read_valid  out  1  one-cycle pulse, indexed read data valid
- busy  out  1  high while in SEARCH
- wr_en  in  1  write entry (accepted in any state)
- wr_address  in  ADDR_W  write index
- wr_key  in  KEY_W  key to store
- wr_data  in  DATA_W  data to store
- wr_valid  in  1  valid bit to store; 0 invalidates the entry

## Operation
- States: IDLE, SEARCH.
- IDLE, match_enable=1:
  - Latch data_in into key_q, set idx=0, go to SEARCH.
  - match_enable has priority over read_enable; a read in that same cycle is dropped and read_valid stays 0.
- IDLE, read_enable=1 (no match_enable): register entry[read_address].data into read_data and pulse read_valid. The valid bit is ignored for indexed reads.
- SEARCH:
  - Compare one entry per cycle: hit when valid[idx] and key[idx]==key_q.
  - On hit: pulse match_found and match_done, register match_address=idx and read_data=data[idx], go to IDLE.
  - On miss at idx=DEPTH-1: pulse match_done only. read_data and match_address hold their previous values. Go to IDLE.
  - Otherwise idx increments. idx never wraps.
  - Lowest index wins.
- match_enable and read_enable received while busy are ignored; they are not queued.
- Writes:
  - Storage updates at the clock edge.
  - A compare or read in the same cycle sees the pre-write value.
  - A write to an index not yet scanned is visible to the ongoing search.
- Outputs are registered. match_found, match_done and read_valid are single-cycle pulses.
- Reset values: match_found=0, match_done=0, match_address=0, read_data=0, read_valid=0, busy=0, state=IDLE, idx=0, all valid bits=0. Key and data arrays are not reset.
- resetn low mid-search aborts the search; no match_done is issued.

## Timing
- Indexed read: request sampled at edge E0; read_data/read_valid visible after E0 (1-cycle latency).
- Search: match_enable sampled at E0; busy high after E0.
  - Hit at index i: result visible after edge E(i+1), i.e. i+1 cycles after the request; busy low in the same cycle.
  - Miss: match_done visible after E(DEPTH), i.e. DEPTH cycles after the request.
- Back-to-back: a new request is accepted in the cycle match_done is high, since the state is already IDLE.

## Configuration
- ROUTE_TABLE_MASK_EN defined:
  - Each entry also stores a KEY_W mask, written from an extra input wr_mask (KEY_W).
  - Hit when valid[idx] and (key[idx] & mask[idx]) == (key_q & mask[idx]). This gives prefix/wildcard routes; the lowest index still wins.
- ROUTE_TABLE_MASK_EN undefined: no mask storage and no wr_mask port; exact-match compare.

## Structure
- Package route_table_pkg: DEPTH/ADDR_W/KEY_W/DATA_W defaults, state enum {IDLE, SEARCH}, entry struct {valid, key, data[, mask]}.
- Sub-module route_table_storage:
  - Register array plus valid bits.
  - Single write port.
  - Two combinational read ports: compare index and read index.
- The FSM, counter and output registers live in route_table_responder.

## Test plan
- Reset, then indexed read at 5 -> read_valid pulses once after 1 cycle, read_data=0; busy=0.
- Write entry 3 {key=46, data=69}, then search key 46 -> match_found and match_done after 4 cycles, match_address=3, read_data=69.
- Search key 99 with no entry holding it -> match_done after 128 cycles, match_found=0, read_data unchanged.
- Entries 2 and 7 both hold key 46 -> hit at 2 reported. Invalidate 2, search again -> hit at 7.
- match_enable and read_enable in the same cycle, plus read_enable while busy -> no read_valid. Pull resetn low at idx=10 -> no match_done; all outputs zero next cycle; a prior entry no longer matches.
- With ROUTE_TABLE_MASK_EN: entry 0 {key=0x0A000000, mask=0xFF000000}, search 0x0A0B0C0D -> hit at 0 after 1 cycle.
